// File: rtl/dma_mem_pkg.sv
// dma_mem_pkg: shared state encoding and default geometry for the DMA memory responder.
package dma_mem_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } state_t;
   localparam int DEF_AW = 4;
   localparam int DEF_DW = 8;
endpackage

// File: rtl/dma_sram_array.sv
// dma_sram_array: 2**AW x DW storage, one write port and one registered read port, no reset.
module dma_sram_array #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: memory-side responder with wait states, level ready handshake,
// backdoor load port and saturating access counters.
module dma_mem_responder
   import dma_mem_pkg::*;
#(
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW,
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_ce_n,
   input  logic             mem_we_n,
   input  logic [AW-1:0]    mem_addr,
   input  logic [DW-1:0]    mem_data_in,
   output logic [DW-1:0]    mem_data_out,
   output logic             mem_ready,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [DW-1:0]    ld_data,
   output logic             ld_err,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count
);
   localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

   state_t        state;
   logic [AW-1:0] addr_q;
   logic          we_n_q;
   logic [DW-1:0] data_q;
   logic [3:0]    wait_cnt;
   logic          idle_free, arr_we, arr_re;
   logic [AW-1:0] arr_waddr, arr_raddr;
   logic [DW-1:0] arr_wdata, arr_rdata;

   assign idle_free = state == IDLE && mem_ce_n;
   // The registered read is launched on the edge that enters ACCESS so its data is ready there.
   assign arr_re    = (state == IDLE && !mem_ce_n && mem_we_n && WAIT_STATES == 0) ||
                      (state == WAIT && wait_cnt == 4'd0 && we_n_q);
   assign arr_raddr = state == IDLE ? mem_addr : addr_q;
   assign arr_we    = (state == ACCESS && !we_n_q) || (idle_free && ld_en);
   assign arr_waddr = state == ACCESS ? addr_q : ld_addr;
   assign arr_wdata = state == ACCESS ? data_q : ld_data;

   dma_sram_array #(.AW(AW), .DW(DW)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (arr_re),
      .raddr (arr_raddr),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         we_n_q       <= 1'b1;
         data_q       <= '0;
         wait_cnt     <= '0;
         mem_data_out <= '0;
         mem_ready    <= 1'b0;
         ld_err       <= 1'b0;
         rd_count     <= '0;
         wr_count     <= '0;
      end else begin
         ld_err <= ld_en && !idle_free;
         case (state)
            IDLE: if (!mem_ce_n) begin
               addr_q   <= mem_addr;
               we_n_q   <= mem_we_n;
               data_q   <= mem_data_in;
               wait_cnt <= WS_M1;
               state    <= WAIT_STATES == 0 ? ACCESS : WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd0) state <= ACCESS;
            end
            ACCESS: begin
               if (we_n_q) begin
                  mem_data_out <= arr_rdata;
                  rd_count     <= rd_count + CNT_W'(rd_count != '1);
               end else
                  wr_count <= wr_count + CNT_W'(wr_count != '1);
               mem_ready <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (mem_ce_n) begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: three responder instances (0, 3 and 1 wait states, one with 2-bit counters)
// driven by random and directed bus traffic, checked against an array-based memory model.
module tb_dma_mem_responder;
   function automatic int ws_of(input int g);
      return g == 1 ? 3 : g == 2 ? 1 : 0;
   endfunction
   function automatic int cw_of(input int g);
      return g == 2 ? 2 : 16;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n [3];
   logic       ce_n [3];
   logic       we_n [3];
   logic [3:0] addr [3];
   logic [7:0] din [3];
   logic [7:0] dout [3];
   logic       ready [3];
   logic       ld_en [3];
   logic [3:0] ld_addr [3];
   logic [7:0] ld_data [3];
   logic       ld_err [3];
   logic [15:0] rdc [3];
   logic [15:0] wrc [3];

   logic [7:0]  mem_m [3][16];
   logic [7:0]  exp_out [3];
   int unsigned rd_m [3];
   int unsigned wr_m [3];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int W = ws_of(g);
      localparam int C = cw_of(g);
      logic [C-1:0] rc, wc;
      dma_mem_responder #(.AW(4), .DW(8), .WAIT_STATES(W), .CNT_W(C)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n[g]),
         .mem_ce_n     (ce_n[g]),
         .mem_we_n     (we_n[g]),
         .mem_addr     (addr[g]),
         .mem_data_in  (din[g]),
         .mem_data_out (dout[g]),
         .mem_ready    (ready[g]),
         .ld_en        (ld_en[g]),
         .ld_addr      (ld_addr[g]),
         .ld_data      (ld_data[g]),
         .ld_err       (ld_err[g]),
         .rd_count     (rc),
         .wr_count     (wc)
      );
      assign rdc[g] = 16'(rc);
      assign wrc[g] = 16'(wc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned bump(input int unsigned v, input int g);
      return v == (2 ** cw_of(g)) - 1 ? v : v + 1;
   endfunction

   task automatic check_counts(input int g);
      chk("rd_count", rdc[g], rd_m[g]);
      chk("wr_count", wrc[g], wr_m[g]);
   endtask

   task automatic load(input int g, input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en[g] = 1'b1; ld_addr[g] = a; ld_data[g] = d;
      @(posedge clk); #1;
      chk("ld_ok", ld_err[g], 1'b0);
      ld_en[g] = 1'b0;
      mem_m[g][a] = d;
   endtask

   task automatic access(input int g, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input int hold, input bit with_ld);
      int k;
      @(negedge clk);
      ce_n[g] = 1'b0; we_n[g] = !wr; addr[g] = a; din[g] = d;
      ld_en[g] = with_ld; ld_addr[g] = a; ld_data[g] = ~d;
      @(posedge clk); #1;
      chk("ld_err", ld_err[g], with_ld);
      ld_en[g] = 1'b0;
      // Bus inputs change after capture; the access must use the captured request.
      addr[g] = 4'($urandom); din[g] = 8'($urandom); we_n[g] = 1'($urandom);
      k = 0;
      while (!ready[g] && k < 40) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) chk("ld_err_pulse", ld_err[g], 1'b0);
      end
      chk("latency", k, ws_of(g) + 1);
      if (wr) begin
         mem_m[g][a] = d;
         wr_m[g] = bump(wr_m[g], g);
      end else begin
         exp_out[g] = mem_m[g][a];
         rd_m[g] = bump(rd_m[g], g);
      end
      chk("data_out", dout[g], exp_out[g]);
      check_counts(g);
      repeat (hold) begin
         @(posedge clk); #1;
         chk("hold_ready", ready[g], 1'b1);
      end
      @(negedge clk);
      ce_n[g] = 1'b1;
      @(posedge clk); #1;
      chk("release", ready[g], 1'b0);
      check_counts(g);
   endtask

   task automatic readback(input int g, input logic [3:0] a);
      access(g, 1'b0, a, 8'h00, 0, 1'b0);
   endtask

   initial begin
      for (int g = 0; g < 3; g++) begin
         rst_n[g] = 1'b0; ce_n[g] = 1'b1; we_n[g] = 1'b1; addr[g] = '0; din[g] = '0;
         ld_en[g] = 1'b0; ld_addr[g] = '0; ld_data[g] = '0;
         exp_out[g] = '0; rd_m[g] = 0; wr_m[g] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("rst_ready", ready[g], 1'b0);
         chk("rst_dout", dout[g], 8'h00);
         chk("rst_ld_err", ld_err[g], 1'b0);
         check_counts(g);
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
      for (int g = 0; g < 3; g++)
         for (int a = 0; a < 16; a++) load(g, 4'(a), 8'($urandom));

      load(0, 4'h5, 8'hAA);
      readback(0, 4'h5);
      chk("t1_data", dout[0], 8'hAA);
      access(0, 1'b1, 4'hA, 8'h3C, 0, 1'b0);
      chk("t2_keep", dout[0], 8'hAA);
      readback(0, 4'hA);
      chk("t2_data", dout[0], 8'h3C);

      access(1, 1'b0, 4'h7, 8'h00, 5, 1'b0);
      for (int g = 0; g < 3; g++) begin
         access(g, 1'b1, 4'h2, 8'h96, 1, 1'b1);
         readback(g, 4'h2);
         chk("t4_bus_wins", dout[g], 8'h96);
      end

      for (int g = 0; g < 3; g++)
         for (int i = 0; i < 25; i++)
            access(g, 1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
                   $urandom_range(0, 5) == 0);

      load(1, 4'h9, 8'h5A);
      readback(1, 4'h9);
      @(negedge clk);
      ce_n[1] = 1'b0; we_n[1] = 1'b0; addr[1] = 4'h9; din[1] = 8'hC3;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n[1] = 1'b0;
      #1;
      chk("t5_ready", ready[1], 1'b0);
      chk("t5_dout", dout[1], 8'h00);
      chk("t5_rd", rdc[1], 0);
      chk("t5_wr", wrc[1], 0);
      ce_n[1] = 1'b1;
      exp_out[1] = '0; rd_m[1] = 0; wr_m[1] = 0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      readback(1, 4'h9);
      chk("t5_old", dout[1], 8'h5A);

      repeat (5) readback(2, 4'($urandom));
      chk("t6_sat", rdc[2], 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
